// File: rtl/rr_control_merge_dataless_pkg.sv
// Shared helpers for the dataless round-robin control merge.
// Holds the clog2 helper and the SIZE/INDEX_TYPE consistency check.
package rr_control_merge_dataless_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit index_width_ok(input int size, input int width);
        return (size >= 1) && (width >= 1) && (width >= clog2(size));
    endfunction

endpackage

// File: rtl/rr_control_merge_dataless_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed priority from input 0
// when RR_CMERGE_FIXED_PRIORITY_EN is defined.
module rr_arbiter
    import rr_control_merge_dataless_pkg::*;
#(
    parameter int SIZE       = 2,
    parameter int INDEX_TYPE = 1
) (
    input  logic [SIZE-1:0]       req,
    input  logic [INDEX_TYPE-1:0] ptr,
    input  logic                  en,
    output logic [SIZE-1:0]       grant,
    output logic [INDEX_TYPE-1:0] grant_idx,
    output logic                  any
);

    int   start;
    int   pos;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
`ifdef RR_CMERGE_FIXED_PRIORITY_EN
        start     = 0;
`else
        start     = int'(ptr);
`endif
        // Scan starting at the pointer, wrapping around modulo SIZE.
        for (int k = 0; k < SIZE; k++) begin
            pos = start + k;
            if (pos >= SIZE) begin
                pos = pos - SIZE;
            end
            if (!found && req[pos]) begin
                found     = 1'b1;
                grant_idx = INDEX_TYPE'(pos);
            end
        end
        any = found;
        if (en && found) begin
            grant = SIZE'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/rr_control_merge_dataless.sv
// Round-robin control merge for dataless tokens with an eager-fork output.
// Define RR_CMERGE_FIXED_PRIORITY_EN for fixed lowest-index priority.
module rr_control_merge_dataless
    import rr_control_merge_dataless_pkg::*;
#(
    parameter int SIZE       = 2,
    parameter int INDEX_TYPE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       ins_valid,
    output logic [SIZE-1:0]       ins_ready,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [INDEX_TYPE-1:0] index,
    output logic                  index_valid,
    input  logic                  index_ready
);

    if (!index_width_ok(SIZE, INDEX_TYPE)) begin : g_bad_params
        $error("rr_control_merge_dataless: INDEX_TYPE too narrow for SIZE");
    end

    logic                  slot_full_q, slot_full_d;
    logic [INDEX_TYPE-1:0] slot_idx_q, slot_idx_d;
    logic                  sent_outs_q, sent_outs_d;
    logic                  sent_idx_q, sent_idx_d;
    logic [INDEX_TYPE-1:0] rr_ptr;

    logic                  done_o, done_i, drain, can_load, load;
    logic [SIZE-1:0]       grant;
    logic [INDEX_TYPE-1:0] grant_idx;
    logic                  any;

    assign outs_valid  = slot_full_q & ~sent_outs_q;
    assign index_valid = slot_full_q & ~sent_idx_q;
    assign index       = slot_idx_q;

    assign done_o   = sent_outs_q | (outs_valid & outs_ready);
    assign done_i   = sent_idx_q | (index_valid & index_ready);
    assign drain    = slot_full_q & done_o & done_i;
    // Reset also blocks acceptance so no token is consumed while held in reset.
    assign can_load = (~slot_full_q | drain) & rst;
    assign load     = any & can_load;

    rr_arbiter #(
        .SIZE      (SIZE),
        .INDEX_TYPE(INDEX_TYPE)
    ) u_arb (
        .req      (ins_valid),
        .ptr      (rr_ptr),
        .en       (can_load),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any)
    );

    assign ins_ready = grant;

    always_comb begin
        slot_full_d = slot_full_q;
        slot_idx_d  = slot_idx_q;
        sent_outs_d = sent_outs_q;
        sent_idx_d  = sent_idx_q;
        if (drain) begin
            sent_outs_d = 1'b0;
            sent_idx_d  = 1'b0;
        end else if (slot_full_q) begin
            sent_outs_d = done_o;
            sent_idx_d  = done_i;
        end
        if (load) begin
            slot_full_d = 1'b1;
            slot_idx_d  = grant_idx;
        end else if (drain) begin
            slot_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full_q <= 1'b0;
            slot_idx_q  <= '0;
            sent_outs_q <= 1'b0;
            sent_idx_q  <= 1'b0;
        end else begin
            slot_full_q <= slot_full_d;
            slot_idx_q  <= slot_idx_d;
            sent_outs_q <= sent_outs_d;
            sent_idx_q  <= sent_idx_d;
        end
    end

`ifdef RR_CMERGE_FIXED_PRIORITY_EN
    assign rr_ptr = '0;
`else
    logic [INDEX_TYPE-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = (int'(grant_idx) == SIZE - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

endmodule

// File: tb/tb_rr_control_merge_dataless.sv
// Self-checking bench for rr_control_merge_dataless (SIZE=4) against a
// behavioural token-slot model; honours RR_CMERGE_FIXED_PRIORITY_EN.
module tb_rr_control_merge_dataless;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] ins_valid;
    logic [N-1:0] ins_ready;
    logic         outs_valid;
    logic         outs_ready;
    logic [W-1:0] index;
    logic         index_valid;
    logic         index_ready;

    int total  = 0;
    int passed = 0;

    // Model: a one-entry token buffer with per-consumer delivered flags.
    bit m_full, m_gotO, m_gotI;
    int m_idx, m_ptr;

    bit           e_ov, e_iv, e_load, e_drain, e_doneO, e_doneI;
    int           e_win;
    logic [N-1:0] e_ready;

    logic [W-1:0] obs_idx;
    logic         obs_ov;

    rr_control_merge_dataless #(
        .SIZE      (N),
        .INDEX_TYPE(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .index      (index),
        .index_valid(index_valid),
        .index_ready(index_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        m_full = 0;
        m_gotO = 0;
        m_gotI = 0;
        m_idx  = 0;
        m_ptr  = 0;
    endtask

    task automatic modelEval();
        e_ov    = m_full && !m_gotO;
        e_iv    = m_full && !m_gotI;
        e_doneO = m_gotO || (e_ov && outs_ready);
        e_doneI = m_gotI || (e_iv && index_ready);
        e_drain = m_full && e_doneO && e_doneI;
        e_win   = -1;
        for (int k = 0; k < N; k++) begin
            int j;
`ifdef RR_CMERGE_FIXED_PRIORITY_EN
            j = k;
`else
            j = (m_ptr + k) % N;
`endif
            if (e_win < 0 && ins_valid[j]) e_win = j;
        end
        e_load  = rst && (!m_full || e_drain) && (e_win >= 0);
        e_ready = e_load ? N'(1 << e_win) : '0;
    endtask

    task automatic modelAdvance();
        if (!rst) begin
            modelReset();
        end else if (e_load) begin
            m_full = 1;
            m_idx  = e_win;
            m_gotO = 0;
            m_gotI = 0;
            m_ptr  = (e_win + 1) % N;
        end else if (e_drain) begin
            m_full = 0;
            m_gotO = 0;
            m_gotI = 0;
        end else if (m_full) begin
            m_gotO = e_doneO;
            m_gotI = e_doneI;
        end
    endtask

    // One clock cycle: drive at edge+1, check at mid-cycle, advance model after the edge.
    task automatic applyStimulus(input string tag, input logic [N-1:0] v, input logic o_r, input logic i_r);
        ins_valid   = v;
        outs_ready  = o_r;
        index_ready = i_r;
        #4;
        modelEval();
        obs_idx = index;
        obs_ov  = outs_valid;
        checkOutput({tag, ".ins_ready"}, 32'(ins_ready), 32'(e_ready));
        checkOutput({tag, ".outs_valid"}, 32'(outs_valid), 32'(e_ov));
        checkOutput({tag, ".index_valid"}, 32'(index_valid), 32'(e_iv));
        checkOutput({tag, ".index"}, 32'(index), 32'(m_idx));
        @(posedge clk);
        #1;
        modelAdvance();
    endtask

    initial begin
        ins_valid   = '0;
        outs_ready  = 1'b0;
        index_ready = 1'b0;
        rst         = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;

        for (int c = 0; c < 4; c++) begin
            applyStimulus("reset", N'($urandom), 1'($urandom), 1'($urandom));
        end

        rst = 1'b1;
        for (int c = 0; c < 9; c++) begin
            applyStimulus("rr", 4'b1111, 1'b1, 1'b1);
            if (c == 0) begin
                checkOutput("rr.first_latency", 32'(obs_ov), 32'd0);
            end else begin
                checkOutput("rr.no_bubble", 32'(obs_ov), 32'd1);
`ifdef RR_CMERGE_FIXED_PRIORITY_EN
                checkOutput("rr.seq", 32'(obs_idx), 32'd0);
`else
                checkOutput("rr.seq", 32'(obs_idx), 32'((c - 1) % N));
`endif
            end
        end

        applyStimulus("flush", 4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus("skew", 4'b0100, 1'b1, 1'b0);
            if (c > 0) checkOutput("skew.index_held", 32'(obs_idx), 32'd2);
        end
        applyStimulus("skew_drain", 4'b0100, 1'b1, 1'b1);
        applyStimulus("skew_after", 4'b0000, 1'b1, 1'b1);

        for (int c = 0; c < 6; c++) begin
            applyStimulus("backpressure", N'($urandom), 1'b0, 1'b0);
        end

        // Drop reset between edges while the slot is stalled full.
        checkOutput("async.pre_full", 32'(m_full), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async.outs_valid", 32'(outs_valid), 32'd0);
        checkOutput("async.index_valid", 32'(index_valid), 32'd0);
        checkOutput("async.index", 32'(index), 32'd0);
        checkOutput("async.ins_ready", 32'(ins_ready), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int c = 0; c < 400; c++) begin
            applyStimulus("random", N'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
